// File: rtl/spi_reg_responder.sv
// SPI mode-0 register responder: 16-bit frames (command byte, data byte) against
// a byte-wide register file, oversampled in the system clock domain.
module spi_reg_responder #(
  parameter int NREGS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs,
  output logic              miso,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_err,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [7:0]        dbg_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic                   sclk_r, sclk_p, mosi_r, cs_r, cs_p;
  logic                   rise, fall;
  logic [1:0]             state;
  logic [2:0]             bit_cnt;
  logic [6:0]             cmd_sr, data_sr;
  logic [7:0]             rd_sr;
  logic                   is_wr;
  logic [ADDR_W-1:0]      addr, addr_n;
  logic [NREGS-1:0][7:0]  mem;

  assign rise     = sclk_r & ~sclk_p;
  assign fall     = ~sclk_r & sclk_p;
  // Address as it will be once the 8th command bit lands this cycle.
  assign addr_n   = ADDR_W'({cmd_sr, mosi_r});
  assign miso     = (state == S_DATA) & ~is_wr & rd_sr[7];
  assign dbg_data = mem[dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_r    <= 1'b0;
      sclk_p    <= 1'b0;
      mosi_r    <= 1'b0;
      cs_r      <= 1'b1;
      cs_p      <= 1'b1;
      state     <= S_IDLE;
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      data_sr   <= '0;
      rd_sr     <= '0;
      is_wr     <= 1'b0;
      addr      <= '0;
      mem       <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      sclk_r    <= sclk;
      sclk_p    <= sclk_r;
      mosi_r    <= mosi;
      cs_r      <= cs;
      cs_p      <= cs_r;
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cs_p & ~cs_r) begin
            state   <= S_CMD;
            bit_cnt <= '0;
          end
        end
        S_CMD: begin
          if (cs_r) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            frame_err <= 1'b1;
          end else if (rise) begin
            cmd_sr  <= {cmd_sr[5:0], mosi_r};
            bit_cnt <= bit_cnt + 3'd1;  // wraps to 0 = data count start
            if (bit_cnt == 3'd7) begin
              state <= S_DATA;
              is_wr <= cmd_sr[6];
              addr  <= addr_n;
              if (!cmd_sr[6]) rd_sr <= mem[addr_n];
            end
          end
        end
        S_DATA: begin
          if (cs_r) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            frame_err <= 1'b1;
          end else if (rise) begin
            data_sr <= {data_sr[5:0], mosi_r};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= S_DONE;
              if (is_wr) begin
                mem[addr] <= {data_sr, mosi_r};
                wr_valid  <= 1'b1;
                wr_addr   <= addr;
                wr_data   <= {data_sr, mosi_r};
              end
            end
          end else if (fall && bit_cnt != 3'd0) begin
            // No shift on the fall right after the load, so bit7 is seen on rise 9.
            rd_sr <= {rd_sr[6:0], 1'b0};
          end
        end
        default: begin
          if (cs_r) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder: bit-banged SPI frames with hand-computed results.
module tb_spi_reg_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, mosi, cs;
  logic       miso;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic [3:0] dbg_addr;
  logic [7:0] dbg_data;

  int errors = 0;
  int checks = 0;

  int         wv_cnt = 0;
  int         fe_cnt = 0;
  logic [3:0] last_wa;
  logic [7:0] last_wd;

  spi_reg_responder #(.NREGS(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid) begin
      wv_cnt  = wv_cnt + 1;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
  end

  task automatic clear_mon();
    wv_cnt = 0;
    fe_cnt = 0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends nbits of frame MSB first plus `extra` dummy pulses; miso is captured
  // just before each data-phase rise. cs is raised afterwards when raise_cs.
  task automatic xfer(input logic [15:0] frame, input int nbits, input int extra,
                      input bit raise_cs, input int gap,
                      output logic [7:0] rd, output logic extra_miso);
    rd = 8'h00;
    extra_miso = 1'b0;
    @(negedge clk);
    cs = 1'b0;
    wait_clk(3);
    for (int i = 0; i < nbits + extra; i++) begin
      mosi = (i < 16) ? frame[15 - i] : 1'b1;
      wait_clk(3);
      if (i >= 8 && i < 16) rd[15 - i] = miso;
      if (i >= 16) extra_miso = extra_miso | miso;
      sclk = 1'b1;
      wait_clk(3);
      if (i >= 16) extra_miso = extra_miso | miso;
      sclk = 1'b0;
    end
    wait_clk(3);
    if (raise_cs) begin
      cs = 1'b1;
      wait_clk(gap);
    end
  endtask

  task automatic dbg_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    dbg_addr = a;
    #1 d = dbg_data;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs = 1'b1; dbg_addr = 4'd0;
    wait_clk(3);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got=%b exp=0", miso); end
    checks++; if (wr_valid !== 1'b0 || wr_addr !== 4'd0 || wr_data !== 8'h00) begin
      errors++; $display("FAIL reset_wr got=%b/%h/%h exp=0/0/00", wr_valid, wr_addr, wr_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    rst = 1'b0;
    wait_clk(2);
    dbg_read(4'd7, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_mem7 got=%h exp=00", d); end
  endtask

  task automatic test_write();
    logic [7:0] rd, d;
    logic em;
    clear_mon();
    xfer(16'h83A5, 16, 0, 1'b1, 4, rd, em);
    checks++; if (wv_cnt !== 1) begin errors++; $display("FAIL write_pulses got=%0d exp=1", wv_cnt); end
    checks++; if (last_wa !== 4'd3 || last_wd !== 8'hA5) begin
      errors++; $display("FAIL write_addr_data got=%h/%h exp=3/a5", last_wa, last_wd); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL write_frame_err got=%0d exp=0", fe_cnt); end
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL write_miso got=%h exp=00", rd); end
    dbg_read(4'd3, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL write_dbg3 got=%h exp=a5", d); end
  endtask

  task automatic test_read();
    logic [7:0] rd, d;
    logic em;
    clear_mon();
    xfer(16'h0300, 16, 0, 1'b1, 4, rd, em);
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL read_miso got=%h exp=a5", rd); end
    checks++; if (wv_cnt !== 0) begin errors++; $display("FAIL read_wr_valid got=%0d exp=0", wv_cnt); end
    dbg_read(4'd3, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL read_mem_unchanged got=%h exp=a5", d); end
  endtask

  task automatic test_short_frame();
    logic [7:0] rd, d;
    logic em;
    clear_mon();
    xfer(16'h85FF, 11, 0, 1'b1, 4, rd, em);
    checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL short_frame_err got=%0d exp=1", fe_cnt); end
    checks++; if (wv_cnt !== 0) begin errors++; $display("FAIL short_no_write got=%0d exp=0", wv_cnt); end
    dbg_read(4'd5, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL short_mem5 got=%h exp=00", d); end
    clear_mon();
    xfer(16'h853C, 16, 0, 1'b1, 4, rd, em);
    dbg_read(4'd5, d);
    checks++; if (d !== 8'h3C || wv_cnt !== 1 || fe_cnt !== 0) begin
      errors++; $display("FAIL short_retry got=%h/%0d/%0d exp=3c/1/0", d, wv_cnt, fe_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rd, d;
    logic em;
    clear_mon();
    xfer(16'h8FFF, 12, 0, 1'b0, 0, rd, em);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (miso !== 1'b0 || wr_valid !== 1'b0 || wr_addr !== 4'd0 || wr_data !== 8'h00 || frame_err !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got=%b/%b/%h/%h/%b exp=0/0/0/00/0", miso, wr_valid, wr_addr, wr_data, frame_err); end
    wait_clk(2);
    rst = 1'b0;
    cs = 1'b1;
    wait_clk(4);
    dbg_read(4'd15, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL midrst_mem15 got=%h exp=00", d); end
    dbg_read(4'd3, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL midrst_mem3_cleared got=%h exp=00", d); end
    checks++; if (wv_cnt !== 0 || fe_cnt !== 0) begin
      errors++; $display("FAIL midrst_no_events got=%0d/%0d exp=0/0", wv_cnt, fe_cnt); end
    clear_mon();
    xfer(16'h8F42, 16, 0, 1'b1, 4, rd, em);
    dbg_read(4'd15, d);
    checks++; if (d !== 8'h42 || wv_cnt !== 1 || last_wa !== 4'd15) begin
      errors++; $display("FAIL midrst_next_frame got=%h/%0d/%h exp=42/1/f", d, wv_cnt, last_wa); end
  endtask

  task automatic test_extra_clocks();
    logic [7:0] rd, d;
    logic em;
    clear_mon();
    xfer(16'h8A77, 16, 8, 1'b1, 4, rd, em);
    checks++; if (wv_cnt !== 1) begin errors++; $display("FAIL extra_pulses got=%0d exp=1", wv_cnt); end
    checks++; if (em !== 1'b0) begin errors++; $display("FAIL extra_miso_done got=%b exp=0", em); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL extra_frame_err got=%0d exp=0", fe_cnt); end
    dbg_read(4'd10, d);
    checks++; if (d !== 8'h77) begin errors++; $display("FAIL extra_mem10 got=%h exp=77", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd, d;
    logic em;
    clear_mon();
    xfer(16'hF011, 16, 0, 1'b1, 2, rd, em);
    xfer(16'hFFEE, 16, 0, 1'b1, 4, rd, em);
    checks++; if (wv_cnt !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", wv_cnt); end
    checks++; if (last_wa !== 4'd15 || last_wd !== 8'hEE) begin
      errors++; $display("FAIL b2b_last got=%h/%h exp=f/ee", last_wa, last_wd); end
    dbg_read(4'd0, d);
    checks++; if (d !== 8'h11) begin errors++; $display("FAIL b2b_mem0 got=%h exp=11", d); end
    dbg_read(4'd15, d);
    checks++; if (d !== 8'hEE) begin errors++; $display("FAIL b2b_mem15 got=%h exp=ee", d); end
    xfer(16'h7000, 16, 0, 1'b1, 4, rd, em);
    checks++; if (rd !== 8'h11) begin errors++; $display("FAIL b2b_read_reserved got=%h exp=11", rd); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_short_frame();
    test_reset_mid_frame();
    test_extra_clocks();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
